// File: rtl/sam_cmd_pkg.sv
// Shared definitions for the SAM RAM command stream: op codes, field layout,
// widths, issuer state encoding and the instruction encoder.
package sam_cmd_pkg;

   localparam int unsigned DATA_W  = 16;
   localparam int unsigned ADDR_W  = 14;
   localparam int unsigned INSTR_W = 32;
   localparam int unsigned CNT_W   = ADDR_W + 1;
   localparam int unsigned OP_W    = 2;

   // Field positions inside an instruction beat
   localparam int unsigned OP_LSB       = 30;
   localparam int unsigned WR_ADDR_LSB  = 16;
   localparam int unsigned WR_DATA_LSB  = 0;
   localparam int unsigned RD_START_LSB = 14;
   localparam int unsigned RD_END_LSB   = 0;

   typedef enum logic [OP_W-1:0] {
      OP_NOP = 2'b00,
      OP_WR  = 2'b01,
      OP_RD  = 2'b10,
      OP_GO  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SEND     = 2'd1,
      WAIT_RSP = 2'd2
   } state_e;

   // High-level request as presented by the requester
   typedef struct packed {
      op_e               op;
      logic [ADDR_W-1:0] addr;
      logic [ADDR_W-1:0] end_addr;
      logic [DATA_W-1:0] data;
   } req_t;

   // Build a single instruction beat; fields not used by the op stay zero
   function automatic logic [INSTR_W-1:0] encode(input req_t r);
      logic [INSTR_W-1:0] beat;
      beat = '0;
      beat[OP_LSB +: OP_W] = r.op;
      case (r.op)
         OP_WR: begin
            beat[WR_ADDR_LSB +: ADDR_W] = r.addr;
            beat[WR_DATA_LSB +: DATA_W] = r.data;
         end
         OP_RD: begin
            beat[RD_START_LSB +: ADDR_W] = r.addr;
            beat[RD_END_LSB +: ADDR_W]   = r.end_addr;
         end
         default: ;
      endcase
      return beat;
   endfunction

   // Recover the op field from a beat (decoder side)
   function automatic op_e decode_op(input logic [INSTR_W-1:0] beat);
      return op_e'(beat[OP_LSB +: OP_W]);
   endfunction

endpackage

// File: rtl/sam_rsp_counter.sv
// Read-response tracking: remaining beat count, inter-beat timeout timer,
// forwarding of response words and last/error flag generation.
module sam_rsp_counter
   import sam_cmd_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              load,
   input  logic [CNT_W-1:0]  load_count,
   input  logic              active,
   input  logic              s_valid,
   input  logic              s_last,
   input  logic [DATA_W-1:0] s_word,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_valid,
   output logic              rsp_last,
   output logic              err_timeout,
   output logic              err_unexpected,
   output logic              done_c
);

   localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] count;
   logic [TMR_W-1:0] timer;
   logic             final_c;
   logic             timeout_c;

   // Final beat of the read, or the last allowed idle cycle expiring
   assign final_c   = active && s_valid && (count == CNT_W'(1));
   assign timeout_c = active && !s_valid && (timer == TMR_W'(TIMEOUT_CYCLES - 1));
   assign done_c    = final_c || timeout_c;

   // Count/timer bookkeeping and registered response/flag outputs
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count          <= '0;
         timer          <= '0;
         rsp_data       <= '0;
         rsp_valid      <= 1'b0;
         rsp_last       <= 1'b0;
         err_timeout    <= 1'b0;
         err_unexpected <= 1'b0;
      end else begin
         rsp_valid      <= 1'b0;
         rsp_last       <= 1'b0;
         err_timeout    <= 1'b0;
         // Beats outside a read, or an s_last that arrives before the final beat
         err_unexpected <= (!active && s_valid) ||
                           (active && s_valid && s_last && !final_c);
         if (load) begin
            count <= load_count;
            timer <= '0;
         end else if (active) begin
            if (s_valid) begin
               rsp_data  <= s_word;
               rsp_valid <= 1'b1;
               rsp_last  <= final_c;
               count     <= count - CNT_W'(1);
               timer     <= '0;
            end else if (timeout_c) begin
               err_timeout <= 1'b1;
               count       <= '0;
               timer       <= '0;
            end else begin
               timer <= timer + TMR_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/sam_cmd_issuer.sv
// Stream initiator for the SAM RAM command block: encodes requester ops into
// single-beat instructions and collects read responses.
module sam_cmd_issuer
   import sam_cmd_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [1:0]         req_op,
   input  logic [ADDR_W-1:0]  req_addr,
   input  logic [ADDR_W-1:0]  req_end_addr,
   input  logic [DATA_W-1:0]  req_data,
   output logic [INSTR_W-1:0] m_data,
   output logic               m_valid,
   input  logic               m_ready,
   output logic               m_last,
   input  logic [INSTR_W-1:0] s_data,
   input  logic               s_valid,
   output logic               s_ready,
   input  logic               s_last,
   output logic [DATA_W-1:0]  rsp_data,
   output logic               rsp_valid,
   output logic               rsp_last,
   output logic               busy,
   output logic               err_range,
   output logic               err_timeout,
   output logic               err_unexpected
);

   state_e             state, state_n;
   req_t               req_in;
   op_e                op_q, op_n;
   logic [ADDR_W-1:0]  start_q, start_n;
   logic [ADDR_W-1:0]  end_q, end_n;
   logic [INSTR_W-1:0] m_data_n;
   logic               m_valid_n;
   logic               err_range_n;
   logic               load_c;
   logic [CNT_W-1:0]   load_count_c;
   logic               done_c;
   logic               unused_hi;

   // Only the low data word of a response beat is forwarded
   assign unused_hi = ^s_data[INSTR_W-1:DATA_W];

   // Pack the requester inputs into one request record
   always_comb begin
      req_in = req_t'({req_op, req_addr, req_end_addr, req_data});
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= IDLE;
         op_q      <= OP_NOP;
         start_q   <= '0;
         end_q     <= '0;
         m_data    <= '0;
         m_valid   <= 1'b0;
         m_last    <= 1'b0;
         req_ready <= 1'b0;
         busy      <= 1'b0;
         s_ready   <= 1'b0;
         err_range <= 1'b0;
      end else begin
         state     <= state_n;
         op_q      <= op_n;
         start_q   <= start_n;
         end_q     <= end_n;
         m_data    <= m_data_n;
         m_valid   <= m_valid_n;
         m_last    <= m_valid_n;
         req_ready <= (state_n == IDLE);
         busy      <= (state_n != IDLE);
         s_ready   <= 1'b1;
         err_range <= err_range_n;
      end
   end

   // Next-state and next-output decode
   always_comb begin
      state_n      = state;
      op_n         = op_q;
      start_n      = start_q;
      end_n        = end_q;
      m_data_n     = m_data;
      m_valid_n    = m_valid;
      err_range_n  = 1'b0;
      load_c       = 1'b0;
      load_count_c = CNT_W'(end_q) - CNT_W'(start_q) + CNT_W'(1);
      case (state)
         IDLE: begin
            if (req_valid && req_ready) begin
               op_n    = req_in.op;
               start_n = req_in.addr;
               end_n   = req_in.end_addr;
               if (req_in.op == OP_NOP) begin
                  state_n = IDLE;
               end else if (req_in.op == OP_RD && req_in.end_addr < req_in.addr) begin
                  err_range_n = 1'b1;
               end else begin
                  m_data_n  = encode(req_in);
                  m_valid_n = 1'b1;
                  state_n   = SEND;
               end
            end
         end
         SEND: begin
            if (m_ready) begin
               m_valid_n = 1'b0;
               if (op_q == OP_RD) begin
                  load_c  = 1'b1;
                  state_n = WAIT_RSP;
               end else begin
                  state_n = IDLE;
               end
            end
         end
         WAIT_RSP: begin
            if (done_c) begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Read-response counting, timeout and flag generation
   sam_rsp_counter #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_rsp_counter (
      .clk            (clk),
      .rstn           (rstn),
      .load           (load_c),
      .load_count     (load_count_c),
      .active         (state == WAIT_RSP),
      .s_valid        (s_valid),
      .s_last         (s_last),
      .s_word         (s_data[DATA_W-1:0]),
      .rsp_data       (rsp_data),
      .rsp_valid      (rsp_valid),
      .rsp_last       (rsp_last),
      .err_timeout    (err_timeout),
      .err_unexpected (err_unexpected),
      .done_c         (done_c)
   );

endmodule
